// File: rtl/atm_keypad_pkg.sv
// Shared key codes, FSM state encoding and defaults for the ATM keypad entry stage.
// Optional binary accumulator is enabled by defining ATM_KEYPAD_BINARY_EN.
package atm_keypad_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BKSP   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000;

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StHold
    } kp_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad-in / entry-out bundle between the keypad entry stage and its environment.
// out_bin is present only when ATM_KEYPAD_BINARY_EN is defined.
interface atm_keypad_entry_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  require_full;
    logic [4*DIGITS-1:0]   out_value;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            digit_count;
    logic                  err_pulse;
    logic                  cancel_pulse;
    logic                  timeout_pulse;
`ifdef ATM_KEYPAD_BINARY_EN
    logic [15:0]           out_bin;

    modport master (
        input  key_valid, key_code, require_full, out_ready,
        output out_value, out_valid, digit_count, err_pulse, cancel_pulse, timeout_pulse,
        output out_bin
    );

    modport slave (
        output key_valid, key_code, require_full, out_ready,
        input  out_value, out_valid, digit_count, err_pulse, cancel_pulse, timeout_pulse,
        input  out_bin
    );
`else
    modport master (
        input  key_valid, key_code, require_full, out_ready,
        output out_value, out_valid, digit_count, err_pulse, cancel_pulse, timeout_pulse
    );

    modport slave (
        output key_valid, key_code, require_full, out_ready,
        input  out_value, out_valid, digit_count, err_pulse, cancel_pulse, timeout_pulse
    );
`endif
endinterface

// File: rtl/atm_keypad_timer.sv
// Idle counter: load clears, enable counts, expire flags the TIMEOUT_CYCLES-1 cycle.
// Load wins over expire, so activity in the expiry cycle restarts the count.
module atm_keypad_timer
    import atm_keypad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = enable && !load && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Collects keypad digits into packed BCD and hands complete entries downstream via valid/ready.
// Define ATM_KEYPAD_BINARY_EN to add the saturating binary accumulator on out_bin.
module atm_keypad_entry
    import atm_keypad_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    atm_keypad_entry_if.master  bus
);
    localparam int unsigned VW   = 4 * DIGITS;
    localparam logic [2:0]  FULL = 3'(DIGITS);

    kp_state_e         state_q, state_d;
    logic [VW-1:0]     value_q, value_d;
    logic [2:0]        count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic              cancel_q, cancel_d;
    logic              timeout_q, timeout_d;
    logic              key_acc, is_cancel, do_clear;
    logic              tmr_load, tmr_expire;

`ifdef ATM_KEYPAD_BINARY_EN
    logic [15:0]       bin_q, bin_d;
    logic              busy_q, busy_d;
    logic [19:0]       bin_mac;

    // The cycle after a backspace belongs to the divider; keys arriving then are dropped.
    assign key_acc = bus.key_valid && (bus.key_code <= KEY_CANCEL) && !busy_q;
    assign bus.out_bin = bin_q;
`else
    assign key_acc = bus.key_valid && (bus.key_code <= KEY_CANCEL);
`endif

    assign is_cancel = key_acc && (bus.key_code == KEY_CANCEL);
    assign tmr_load  = key_acc || (state_q != StEntry);

    atm_keypad_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .enable (state_q == StEntry),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        cancel_d    = 1'b0;
        timeout_d   = 1'b0;
        do_clear    = 1'b0;
`ifdef ATM_KEYPAD_BINARY_EN
        bin_d   = bin_q;
        busy_d  = 1'b0;
        bin_mac = 20'(bin_q) * 20'd10 + 20'(bus.key_code);
`endif
        if (state_q == StHold) begin
            // Ready and cancel both end the hold; any other key is dropped silently.
            if (bus.out_ready || is_cancel) begin
                do_clear = 1'b1;
                cancel_d = is_cancel;
            end
        end else if (key_acc) begin
            if (is_digit(bus.key_code)) begin
                if (count_q == FULL) begin
                    err_d = 1'b1;
                end else begin
                    value_d = {value_q[VW-5:0], bus.key_code};
                    count_d = count_q + 3'd1;
                    state_d = StEntry;
`ifdef ATM_KEYPAD_BINARY_EN
                    bin_d = (|bin_mac[19:16]) ? 16'hFFFF : bin_mac[15:0];
`endif
                end
            end else begin
                case (bus.key_code)
                    KEY_CLEAR: do_clear = 1'b1;
                    KEY_BKSP: begin
                        if (count_q != 3'd0) begin
                            value_d = value_q >> 4;
                            count_d = count_q - 3'd1;
                            if (count_q == 3'd1) state_d = StIdle;
`ifdef ATM_KEYPAD_BINARY_EN
                            bin_d  = bin_q / 16'd10;
                            busy_d = 1'b1;
`endif
                        end
                    end
                    KEY_ENTER: begin
                        if (count_q != 3'd0) begin
                            if (bus.require_full && (count_q != FULL)) begin
                                err_d = 1'b1;
                            end else begin
                                state_d     = StHold;
                                out_valid_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        do_clear = 1'b1;
                        cancel_d = 1'b1;
                    end
                endcase
            end
        end else if (tmr_expire) begin
            do_clear  = 1'b1;
            timeout_d = 1'b1;
        end

        if (do_clear) begin
            state_d     = StIdle;
            value_d     = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
`ifdef ATM_KEYPAD_BINARY_EN
            bin_d       = '0;
            busy_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            value_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cancel_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ATM_KEYPAD_BINARY_EN
            bin_q       <= '0;
            busy_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            cancel_q    <= cancel_d;
            timeout_q   <= timeout_d;
`ifdef ATM_KEYPAD_BINARY_EN
            bin_q       <= bin_d;
            busy_q      <= busy_d;
`endif
        end
    end

    assign bus.out_value     = value_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.digit_count   = count_q;
    assign bus.err_pulse     = err_q;
    assign bus.cancel_pulse  = cancel_q;
    assign bus.timeout_pulse = timeout_q;

endmodule
